// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
//   Bundles the fetch-side, execute-side and writeback signals of the decode
//   stage.  The slave modport is the decode stage itself; the master modport
//   is whatever surrounds it (pipeline neighbours or a testbench).
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where valid and ready are both high.  A producer that raises valid
//   keeps its payload stable until the transfer.  ready may depend
//   combinationally on valid, never the other way round.  flush cancels the
//   execute-side transfer and blocks the fetch-side capture for that cycle.
//
//   Signals:
//     flush                  kill held instruction, block capture
//     in_valid/in_ready      fetch handshake, in_inst is the payload
//     out_valid/out_ready    execute handshake, out_* fields are the payload
//     wb_valid/wb_dest       writeback retiring a register write
//     busy_mask              scoreboard, one bit per register
//     hazard                 incoming instruction blocked by a dependency
// ---------------------------------------------------------------------------
interface decode_stage_if #(
   parameter int OPC_W  = 4,
   parameter int REG_W  = 3,
   parameter int ADDR_W = 4
);
   localparam int INST_W = OPC_W + 3 * REG_W;
   localparam int NREG   = 1 << REG_W;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [INST_W-1:0] in_inst;
   logic              out_valid;
   logic              out_ready;
   logic [OPC_W-1:0]  out_opcode;
   logic [ADDR_W-1:0] out_addr;
   logic [REG_W-1:0]  out_opa;
   logic [REG_W-1:0]  out_opb;
   logic [REG_W-1:0]  out_dest;
   logic              out_wr_en;
   logic              wb_valid;
   logic [REG_W-1:0]  wb_dest;
   logic [NREG-1:0]   busy_mask;
   logic              hazard;

   modport slave (
      input  flush, in_valid, in_inst, out_ready, wb_valid, wb_dest,
      output in_ready, out_valid, out_opcode, out_addr, out_opa, out_opb,
             out_dest, out_wr_en, busy_mask, hazard
   );

   modport master (
      output flush, in_valid, in_inst, out_ready, wb_valid, wb_dest,
      input  in_ready, out_valid, out_opcode, out_addr, out_opa, out_opb,
             out_dest, out_wr_en, busy_mask, hazard
   );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction-decode stage of the lab processor pipeline.  Splits a fetched
//   instruction into opcode / address / operand / destination fields, holds
//   them in a single pipeline register, and keeps a register scoreboard so
//   that instructions reading or re-writing a register with a pending write
//   are stalled until writeback retires that register.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (synchronous release expected)
//     bus    decode_stage_if.slave: fetch handshake, execute handshake,
//            writeback, scoreboard and hazard outputs
//
//   Instruction layout (INST_W = OPC_W + 3*REG_W):
//     [INST_W-1 -: OPC_W] opcode | [3*REG_W-1 -: REG_W] opa |
//     [2*REG_W-1 -: REG_W] opb   | [REG_W-1:0] dest
//   JMP_OPC reuses the bits below the opcode as an ADDR_W address field
//   (ADDR_W must not exceed 2*REG_W), has no operands and writes no register.
//   IMM_OPC has no register operands but still writes dest.
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter int               OPC_W   = 4,
   parameter int               REG_W   = 3,
   parameter int               ADDR_W  = 4,
   parameter int               INST_W  = OPC_W + 3 * REG_W,
   parameter logic [OPC_W-1:0] JMP_OPC = 4'b1111,
   parameter logic [OPC_W-1:0] IMM_OPC = 4'b1110
) (
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);
   localparam int NREG = 1 << REG_W;

   // ---------------- pipeline register and scoreboard ----------------
   logic              r_out_valid;
   logic [OPC_W-1:0]  r_out_opcode;
   logic [ADDR_W-1:0] r_out_addr;
   logic [REG_W-1:0]  r_out_opa;
   logic [REG_W-1:0]  r_out_opb;
   logic [REG_W-1:0]  r_out_dest;
   logic              r_out_wr_en;
   logic [NREG-1:0]   r_busy;

   // ---------------- combinational decode of in_inst ----------------
   logic [OPC_W-1:0]  w_opcode;
   logic              w_is_jmp;
   logic              w_uses_ops;
   logic [ADDR_W-1:0] w_addr;
   logic [REG_W-1:0]  w_opa;
   logic [REG_W-1:0]  w_opb;
   logic [REG_W-1:0]  w_dest;
   logic              w_wr_en;

   always_comb begin
      w_opcode   = bus.in_inst[INST_W-1 -: OPC_W];
      w_is_jmp   = (w_opcode == JMP_OPC);
      w_uses_ops = !w_is_jmp && (w_opcode != IMM_OPC);
      w_addr     = w_is_jmp   ? bus.in_inst[INST_W-OPC_W-1 -: ADDR_W] : '0;
      w_opa      = w_uses_ops ? bus.in_inst[3*REG_W-1 -: REG_W]       : '0;
      w_opb      = w_uses_ops ? bus.in_inst[2*REG_W-1 -: REG_W]       : '0;
      w_dest     = bus.in_inst[REG_W-1:0];
      w_wr_en    = !w_is_jmp;
   end

   // ---------------- handshakes ----------------
   logic w_out_fire;
   logic w_hazard;
   logic w_in_ready;
   logic w_capture;

   // The held instruction fires into execute only when not flushed, so a
   // flushed instruction never reaches the scoreboard.
   assign w_out_fire = r_out_valid && bus.out_ready && !bus.flush;

   // Per-register pending write.  A register counts as pending while it is
   // busy in the scoreboard or is the destination of the held instruction;
   // a writeback retiring it in this same cycle bypasses the pending state.
   logic [NREG-1:0] w_pend;
   logic [NREG-1:0] w_busy_set;
   logic [NREG-1:0] w_busy_clr;

   always_comb begin
      w_pend     = '0;
      w_busy_set = '0;
      w_busy_clr = '0;
      for (int i = 0; i < NREG; i++) begin
         w_busy_clr[i] = bus.wb_valid && (bus.wb_dest == REG_W'(i));
         w_busy_set[i] = w_out_fire && r_out_wr_en && (r_out_dest == REG_W'(i));
         w_pend[i]     = (r_busy[i] ||
                          (r_out_valid && r_out_wr_en && (r_out_dest == REG_W'(i))))
                         && !w_busy_clr[i];
      end
   end

   // RAW on either used operand, or WAW on the destination.
   assign w_hazard   = bus.in_valid &&
                       ((w_uses_ops && (w_pend[w_opa] || w_pend[w_opb])) ||
                        (w_wr_en && w_pend[w_dest]));

   // in_ready deliberately ignores flush; flush only suppresses the capture.
   assign w_in_ready = !w_hazard && (!r_out_valid || bus.out_ready);
   assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

   // ---------------- state update ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_opcode <= '0;
         r_out_addr   <= '0;
         r_out_opa    <= '0;
         r_out_opb    <= '0;
         r_out_dest   <= '0;
         r_out_wr_en  <= 1'b0;
         r_busy       <= '0;
      end else begin
         // Set takes priority over a same-cycle writeback clear of the same
         // bit: the issuing write is newer than the one retiring.
         r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;

         if (bus.flush) begin
            r_out_valid <= 1'b0;
         end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_opcode <= w_opcode;
            r_out_addr   <= w_addr;
            r_out_opa    <= w_opa;
            r_out_opb    <= w_opb;
            r_out_dest   <= w_dest;
            r_out_wr_en  <= w_wr_en;
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // ---------------- outputs ----------------
   assign bus.in_ready   = w_in_ready;
   assign bus.hazard     = w_hazard;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_opcode = r_out_opcode;
   assign bus.out_addr   = r_out_addr;
   assign bus.out_opa    = r_out_opa;
   assign bus.out_opb    = r_out_opb;
   assign bus.out_dest   = r_out_dest;
   assign bus.out_wr_en  = r_out_wr_en;
   assign bus.busy_mask  = r_busy;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed scenarios followed by randomized traffic.  A reference model
//   (decoded-instruction queue plus a set of registers with outstanding
//   writes) predicts every output at each falling clock edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   typedef struct packed {
      logic [3:0] opc;
      logic [3:0] addr;
      logic [2:0] opa;
      logic [2:0] opb;
      logic [2:0] dest;
      logic       wr;
   } dec_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   decode_stage_if #(.OPC_W(4), .REG_W(3), .ADDR_W(4)) bus ();

   decode_stage #(.OPC_W(4), .REG_W(3), .ADDR_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   dec_t       exp_q[$];
   dec_t       m_last;
   logic [7:0] m_busy;
   int         n_checks;
   int         n_fail;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decode written from the field rules with plain arithmetic.
   function automatic dec_t decode_ref(input logic [12:0] inst);
      int   w;
      int   opc;
      dec_t d;
      w      = int'(inst);
      opc    = w / 512;
      d      = '0;
      d.opc  = 4'(opc);
      d.dest = 3'(w % 8);
      d.wr   = (opc != 15);
      if (opc == 15) begin
         d.addr = 4'((w / 32) % 16);
      end else if (opc != 14) begin
         d.opa = 3'((w / 64) % 8);
         d.opb = 3'((w / 8) % 8);
      end
      return d;
   endfunction

   function automatic bit pend_ref(input int r, input logic [7:0] busy,
                                   input bit held_v, input dec_t held,
                                   input logic wbv, input logic [2:0] wbd);
      bit writing;
      writing = busy[r] || (held_v && held.wr && int'(held.dest) == r);
      return writing && !(wbv && int'(wbd) == r);
   endfunction

   function automatic dec_t dut_fields();
      return {bus.out_opcode, bus.out_addr, bus.out_opa, bus.out_opb,
              bus.out_dest, bus.out_wr_en};
   endfunction

   // ---------------- monitor / model (falling edge) ----------------
   initial begin
      dec_t       cur;
      dec_t       held;
      dec_t       item;
      bit         held_v;
      bit         uses;
      bit         exp_haz;
      bit         exp_rdy;
      logic [7:0] set_m;
      logic [7:0] clr_m;
      m_busy = '0;
      m_last = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_busy = '0;
            m_last = '0;
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_fields", 32'(dut_fields()), 0);
            chk("rst_busy", 32'(bus.busy_mask), 0);
            chk("rst_hazard", 32'(bus.hazard), 0);
            continue;
         end
         held_v  = (exp_q.size() > 0);
         held    = held_v ? exp_q[0] : '0;
         cur     = decode_ref(bus.in_inst);
         uses    = (int'(cur.opc) < 14);
         exp_haz = bus.in_valid &&
                   ((uses && (pend_ref(int'(cur.opa), m_busy, held_v, held, bus.wb_valid, bus.wb_dest) ||
                              pend_ref(int'(cur.opb), m_busy, held_v, held, bus.wb_valid, bus.wb_dest))) ||
                    (cur.wr && pend_ref(int'(cur.dest), m_busy, held_v, held, bus.wb_valid, bus.wb_dest)));
         exp_rdy = !exp_haz && (!held_v || bus.out_ready);

         chk("hazard", 32'(bus.hazard), 32'(exp_haz));
         chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("out_valid", 32'(bus.out_valid), 32'(held_v));
         chk("out_fields", 32'(dut_fields()), 32'(m_last));
         chk("busy_mask", 32'(bus.busy_mask), 32'(m_busy));

         set_m = '0;
         if (bus.out_valid && (bus.out_ready || bus.flush)) begin
            if (exp_q.size() == 0) begin
               chk("spurious_output", 32'(bus.out_valid), 0);
            end else begin
               item = exp_q.pop_front();
               if (!bus.flush) begin
                  chk("retired_inst", 32'(dut_fields()), 32'(item));
                  if (item.wr) set_m[item.dest] = 1'b1;
               end
            end
         end
         clr_m = '0;
         if (bus.wb_valid) clr_m[bus.wb_dest] = 1'b1;
         m_busy = (m_busy & ~clr_m) | set_m;

         if (bus.in_valid && exp_rdy && !bus.flush) begin
            exp_q.push_back(cur);
            m_last = cur;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pick_wb(input int pct);
      int idx[$];
      for (int i = 0; i < 8; i++) if (m_busy[i]) idx.push_back(i);
      bus.wb_valid = ($urandom_range(0, 99) < pct);
      if (idx.size() > 0 && $urandom_range(0, 99) < 85)
         bus.wb_dest = 3'(idx[$urandom_range(0, idx.size() - 1)]);
      else
         bus.wb_dest = 3'($urandom_range(0, 7));
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = '0;
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_dest   = '0;
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      repeat (2) step();
      rst_n = 1'b1;

      // ADD d=3: one-cycle latency, scoreboard set after issue
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 13'h0253;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("add_valid", 32'(bus.out_valid), 1);
      chk("add_fields", 32'({bus.out_opa, bus.out_opb, bus.out_dest, bus.out_wr_en}), 32'({3'd1, 3'd2, 3'd3, 1'b1}));
      step();
      @(negedge clk);
      chk("add_busy", 32'(bus.busy_mask), 32'h08);
      bus.wb_valid = 1'b0;
      step();
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 3'd3;
      step();
      bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("wb_clear", 32'(bus.busy_mask), 0);

      // JMP: address field, no operands, no write
      step();
      bus.in_valid = 1'b1;
      bus.in_inst  = 13'h1F40;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("jmp_fields", 32'(dut_fields()), 32'({4'hF, 4'hA, 3'd0, 3'd0, 3'd0, 1'b0}));
      step();
      @(negedge clk);
      chk("jmp_busy", 32'(bus.busy_mask), 0);

      // RAW: reader of r3 stalls until writeback of r3
      step();
      bus.in_valid = 1'b1;
      bus.in_inst  = 13'h0253;
      step();
      bus.in_inst = 13'h02D4;
      @(negedge clk);
      chk("raw_hazard_held", 32'(bus.hazard), 1);
      chk("raw_ready_held", 32'(bus.in_ready), 0);
      step();
      @(negedge clk);
      chk("raw_busy", 32'(bus.busy_mask), 32'h08);
      chk("raw_hazard_busy", 32'(bus.hazard), 1);
      step();
      @(negedge clk);
      chk("raw_hazard_wait", 32'(bus.hazard), 1);
      step();
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 3'd3;
      @(negedge clk);
      chk("raw_bypass_hazard", 32'(bus.hazard), 0);
      chk("raw_bypass_ready", 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("raw_reader_opa", 32'({bus.out_valid, bus.out_opa}), 32'({1'b1, 3'd3}));
      step();
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 3'd4;
      step();
      bus.wb_valid = 1'b0;

      // Backpressure: hold for 3 cycles, then stream at 1 per cycle
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 13'h0001;
      step();
      bus.in_inst = 13'h0002;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(bus.in_ready), 0);
         chk("stall_dest", 32'({bus.out_valid, bus.out_dest}), 32'({1'b1, 3'd1}));
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("stream_ready", 32'(bus.in_ready), 1);
      step();
      bus.in_inst = 13'h0003;
      @(negedge clk);
      chk("stream_dest2", 32'(bus.out_dest), 2);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("stream_dest3", 32'(bus.out_dest), 3);
      step();
      bus.wb_valid = 1'b1;
      for (int r = 1; r <= 3; r++) begin
         bus.wb_dest = 3'(r);
         step();
      end
      bus.wb_valid = 1'b0;
      @(negedge clk);
      chk("stream_clean", 32'(bus.busy_mask), 0);

      // Flush while holding d=5
      step();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_inst   = 13'h0005;
      step();
      bus.flush     = 1'b1;
      bus.in_inst   = 13'h0006;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(bus.in_ready), 1);
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.out_valid), 0);
      chk("flush_busy5", 32'(bus.busy_mask[5]), 0);
      chk("flush_no_capture", 32'(bus.out_dest), 5);

      // Same-cycle issue and writeback of r2, then reset mid-stall
      step();
      bus.in_valid = 1'b1;
      bus.in_inst  = 13'h0002;
      step();
      bus.in_valid = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_dest  = 3'd2;
      step();
      bus.wb_valid = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_inst  = 13'h0284;
      @(negedge clk);
      chk("set_wins", 32'(bus.busy_mask), 32'h04);
      chk("stall_before_reset", 32'(bus.hazard), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.out_valid), 0);
      chk("async_rst_fields", 32'(dut_fields()), 0);
      chk("async_rst_busy", 32'(bus.busy_mask), 0);
      chk("async_rst_hazard", 32'(bus.hazard), 0);
      chk("async_rst_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.in_valid  = ($urandom_range(0, 99) < 70);
         bus.in_inst   = 13'($urandom_range(0, 8191));
         bus.out_ready = ($urandom_range(0, 99) < 75);
         bus.flush     = ($urandom_range(0, 99) < 4);
         pick_wb(40);
      end

      // Drain: retire everything still held or outstanding
      step();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      bus.wb_valid  = 1'b0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (exp_q.size() == 0 && m_busy == 8'h00) break;
         pick_wb(100);
      end
      bus.wb_valid = 1'b0;
      step();
      @(negedge clk);
      chk("drain_empty", 32'({exp_q.size() != 0, m_busy}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage (D of F D X M W) for the lab processor.
- Splits a fetched instruction into opcode, address, operand and destination fields and holds them in one pipeline register with valid/ready handshakes on both sides.
- Keeps a register scoreboard and stalls fetch on RAW/WAW hazards until writeback clears the busy register.

Parameters:
- OPC_W, 4, opcode field width
- REG_W, 3, register-index width; NREG = 2**REG_W registers
- ADDR_W, 4, address field width; must satisfy ADDR_W <= 2*REG_W
- INST_W, OPC_W+3*REG_W (13), instruction width
- JMP_OPC, 4'b1111, opcode carrying an address field, no operands, no register write
- IMM_OPC, 4'b1110, opcode with no register operands

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the held instruction and block capture this cycle
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decode accepts instruction this cycle
- in_inst  in  INST_W  instruction word
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts held instruction
- out_opcode  out  OPC_W  inst[INST_W-1 -: OPC_W]
- out_addr  out  ADDR_W  inst[INST_W-OPC_W-1 -: ADDR_W] if opcode==JMP_OPC, else 0
- out_opa  out  REG_W  inst[3*REG_W-1 -: REG_W] unless JMP_OPC/IMM_OPC, else 0
- out_opb  out  REG_W  inst[2*REG_W-1 -: REG_W] unless JMP_OPC/IMM_OPC, else 0
- out_dest  out  REG_W  inst[REG_W-1:0], always
- out_wr_en  out  1  opcode != JMP_OPC
- wb_valid  in  1  writeback retiring a register write
- wb_dest  in  REG_W  register being written back
- busy_mask  out  NREG  scoreboard, bit r set = write to r pending
- hazard  out  1  in_valid high and the instruction is blocked by a dependency

Behaviour:
- Reset (async assert, sync release): out_valid=0, every out_* field 0, busy_mask=0.
- Field decode is combinational on in_inst and registered on capture; latency in->out is 1 cycle.
- Operands used = opa and opb, except when opcode is JMP_OPC or IMM_OPC, where no operands are used.
- pend(r) = busy_mask[r] OR (out_valid AND out_wr_en AND out_dest==r) AND NOT (wb_valid AND wb_dest==r). Writeback in the same cycle counts as a bypass.
- hazard = in_valid AND (any used operand with pend true, OR dest_wr AND pend(dest)). WAW also stalls.
- in_ready = NOT hazard AND (NOT out_valid OR out_ready). in_ready is independent of flush.
- Capture when in_valid AND in_ready AND NOT flush: load fields and set out_valid=1.
- out handshake (out_valid AND out_ready AND NOT flush):
  - if out_wr_en, set busy_mask[out_dest];
  - out_valid clears unless a new capture occurs the same cycle.
- Writeback: wb_valid clears busy_mask[wb_dest].
- If set and clear hit the same bit in the same cycle, set wins.
- flush:
  - out_valid becomes 0 next cycle and no capture occurs;
  - the held instruction never sets the scoreboard;
  - busy_mask is untouched, because downstream writes still retire.
- Holding: out_* fields stay stable while out_valid AND NOT out_ready. in_inst is ignored when in_valid=0.
- Writeback to a register that is not busy: no effect, no error.
- Reset mid-stall: all state cleared immediately; hazard recomputes from the empty scoreboard.

Test Plan:
- ADD 13'h0253 (op 0001, a=1, b=2, d=3), out_ready=1 → 1 cycle later out_valid=1, opa=1, opb=2, dest=3, wr_en=1; the following cycle busy_mask=8'h08.
- JMP 13'h1F40 (op 1111, addr 1010) → out_addr=4'hA, opa=opb=0, dest=0, wr_en=0; busy_mask unchanged.
- ADD d=3, then a reader with a=3 (13'h02D4) → hazard=1 and in_ready=0 until wb_valid with wb_dest=3. The reader is accepted the same cycle wb_valid is asserted.
- out_ready=0 for 3 cycles with in_valid=1 → out fields stable, in_ready=0, no instruction lost or duplicated. Back-to-back independent instructions flow at 1 per cycle once out_ready=1.
- flush while out_valid=1 holding d=5 → out_valid=0 next cycle, busy_mask[5] stays 0, and an instruction on in_inst that cycle is not captured.
- Same-cycle issue of d=2 and wb_dest=2 → busy_mask[2]=1. Then rst_n low mid-stall → all outputs 0 immediately.
